// File: rtl/adu_pkg.sv
// Shared types and constants for the flag event queue.
package adu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fsm_state_t;

    localparam int HOLDOFF_DEFAULT = 4;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter; simultaneous inc and dec leave the count unchanged.
module sat_updown_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    logic [W-1:0] count_q, count_d;

    assign full  = &count_q;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flag_event_queue.sv
// Queues single-cycle flags and hands them to a consumer one request at a time.
// Optional post-ack holdoff state is built when FLAG_EVENT_QUEUE_HOLDOFF_EN is defined.
module flag_event_queue
    import adu_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_in,
    input  logic             evt_ack,
    input  logic             clr_ovf,
    output logic             evt_req,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [31:0]      total_cnt
);

    if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_holdoff_range
        $error("flag_event_queue: HOLDOFF must be in 1..255");
    end

    fsm_state_t        state_q, state_d;
    logic              evt_req_q, evt_req_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       total_q, total_d;
    logic [CNT_W-1:0]  pending_w;
    logic              full_w;
    logic              ack_ok;
    logic              accept;
    logic              drop;

    // An ack only counts while a request is outstanding, so pending cannot underflow.
    assign ack_ok = (state_q == ST_REQ) && evt_ack;
    assign accept = flag_in && (!full_w || ack_ok);
    assign drop   = flag_in && full_w && !ack_ok;

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .dec   (ack_ok),
        .count (pending_w),
        .full  (full_w)
    );

`ifdef FLAG_EVENT_QUEUE_HOLDOFF_EN
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

    logic [7:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_w != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (evt_ack) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_w != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (evt_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

    always_comb begin
        evt_req_d = (state_d == ST_REQ);
        total_d   = total_q + 32'(accept);
        // A drop on the same edge as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            evt_req_q  <= 1'b0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            evt_req_q  <= evt_req_d;
            overflow_q <= overflow_d;
            total_q    <= total_d;
        end
    end

    assign evt_req   = evt_req_q;
    assign pending   = pending_w;
    assign overflow  = overflow_q;
    assign total_cnt = total_q;

endmodule

// File: tb/tb_flag_event_queue.sv
// Directed bench for flag_event_queue: an 8-bit and a 2-bit pending counter instance.
module tb_flag_event_queue;

`ifdef FLAG_EVENT_QUEUE_HOLDOFF_EN
    localparam int EXP_GAP = 4 + 1;
`else
    localparam int EXP_GAP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        f, a, c;
    logic        f2, a2, c2;
    logic        evt_req, overflow;
    logic [7:0]  pending;
    logic [31:0] total_cnt;
    logic        evt_req2, overflow2;
    logic [1:0]  pending2;
    logic [31:0] total_cnt2;

    int vectors;
    int miscompares;

    flag_event_queue dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_in   (f),
        .evt_ack   (a),
        .clr_ovf   (c),
        .evt_req   (evt_req),
        .pending   (pending),
        .overflow  (overflow),
        .total_cnt (total_cnt)
    );

    flag_event_queue #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_in   (f2),
        .evt_ack   (a2),
        .clr_ovf   (c2),
        .evt_req   (evt_req2),
        .pending   (pending2),
        .overflow  (overflow2),
        .total_cnt (total_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  highs;
        int  gaps_bad;
        int  low_run;
        bit  seen;
        int  req_after_rst;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        f = 0; a = 0; c = 0;
        f2 = 0; a2 = 0; c2 = 0;

        #2;
        check("rst_evt_req", 32'(evt_req), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_total", total_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // single flag on the first edge after release, ack 3 cycles after request
        f = 1;
        tick();
        f = 0;
        check("t1_pending_after_flag", 32'(pending), 1);
        check("t1_req_not_yet", 32'(evt_req), 0);
        tick();
        check("t1_req_high", 32'(evt_req), 1);
        tick();
        tick();
        check("t1_req_held", 32'(evt_req), 1);
        check("t1_pending_held", 32'(pending), 1);
        a = 1;
        tick();
        a = 0;
        check("t1_pending_after_ack", 32'(pending), 0);
        check("t1_req_dropped", 32'(evt_req), 0);
        check("t1_total", total_cnt, 1);
        a = 1;
        tick();
        a = 0;
        check("t1_stray_ack_pending", 32'(pending), 0);
        check("t1_stray_ack_req", 32'(evt_req), 0);

        // five back-to-back flags with ack held high
        highs = 0; gaps_bad = 0; low_run = 0; seen = 0;
        f = 1; a = 1;
        for (int i = 0; i < 80; i++) begin
            if (i == 5) f = 0;
            tick();
            if (evt_req) begin
                if (seen && low_run != EXP_GAP) gaps_bad++;
                highs++;
                seen = 1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        a = 0;
        check("t2_handshakes", 32'(highs), 5);
        check("t2_bad_gaps", 32'(gaps_bad), 0);
        check("t2_pending_drained", 32'(pending), 0);
        check("t2_total", total_cnt, 6);

        // same-edge flag and ack with pending = 2
        f = 1;
        tick();
        tick();
        f = 0;
        check("t3_pending_2", 32'(pending), 2);
        check("t3_req_high", 32'(evt_req), 1);
        f = 1; a = 1;
        tick();
        f = 0; a = 0;
        check("t3_same_edge_pending", 32'(pending), 2);
        check("t3_same_edge_total", total_cnt, 9);

        // build pending = 4 in REQ, then reset asynchronously
        f = 1;
        tick();
        tick();
        f = 0;
        for (int i = 0; i < 20 && !evt_req; i++) tick();
        check("t4_req_before_rst", 32'(evt_req), 1);
        check("t4_pending_4", 32'(pending), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_evt_req", 32'(evt_req), 0);
        check("t4_async_pending", 32'(pending), 0);
        check("t4_async_total", total_cnt, 0);
        check("t4_async_overflow", 32'(overflow), 0);
        #1;
        rst_n = 1'b1;
        req_after_rst = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_req || pending != 0) req_after_rst++;
        end
        check("t4_no_reissue", 32'(req_after_rst), 0);

        // CNT_W = 2 saturation and overflow handling
        f2 = 1;
        tick();
        tick();
        tick();
        tick();
        f2 = 0;
        check("t5_pending_sat", 32'(pending2), 3);
        check("t5_overflow_set", 32'(overflow2), 1);
        check("t5_total_3", total_cnt2, 3);
        check("t5_req_high", 32'(evt_req2), 1);
        tick();
        check("t5_overflow_sticky", 32'(overflow2), 1);
        c2 = 1;
        tick();
        c2 = 0;
        check("t5_overflow_cleared", 32'(overflow2), 0);
        f2 = 1; c2 = 1;
        tick();
        f2 = 0;
        check("t5_set_wins", 32'(overflow2), 1);
        check("t5_drop_total", total_cnt2, 3);
        tick();
        c2 = 0;
        check("t5_clear_again", 32'(overflow2), 0);
        f2 = 1; a2 = 1;
        tick();
        f2 = 0; a2 = 0;
        check("t5_full_ack_pending", 32'(pending2), 3);
        check("t5_full_ack_no_ovf", 32'(overflow2), 0);
        check("t5_full_ack_total", total_cnt2, 4);
        check("t5_full_ack_req_low", 32'(evt_req2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
